// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode decoupling queue with fetch throttling
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INSN = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  input  logic                       in_pred_taken,
  output logic                       in_ready,
  output logic                       fetch_en,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic                       out_pred_taken,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic            mem_pred  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          inflight;
  logic          ovf_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign pop   = !empty && out_ready;
  // A full queue still takes a new entry when the head leaves in the same cycle.
  assign push  = in_valid && (!full || pop);

  // A granted fetch returns data one cycle later, so reserve a slot for it.
  assign fetch_en = ({1'b0, cnt} + {{CW{1'b0}}, inflight}) < {1'b0, FULL_CNT};

  assign in_ready       = !full;
  assign out_valid      = !empty;
  assign out_pc         = empty ? '0 : mem_pc[rd_ptr];
  assign out_instr      = empty ? NOP_INSN : mem_instr[rd_ptr];
  assign out_pred_taken = empty ? 1'b0 : mem_pred[rd_ptr];
  assign count          = cnt;
  assign overflow       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fetch_en;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                             ovf_q <= 1'b0;
    else if (in_valid && full && !pop)   ovf_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
      mem_pred[wr_ptr]  <= in_pred_taken;
    end
  end

endmodule
